// File: rtl/icap_reboot_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : icap_reboot_seq_pkg
// Purpose  : Shared constants for the ICAP reboot sequencer. These are the
//            Spartan-6 configuration command words, the FSM state encoding
//            and the sequence length. The same values are used by the boot
//            register block and by software.
// Revision : 1.0 - initial release
// ============================================================================
package icap_reboot_seq_pkg;

    // Configuration packet words. They are stored un-swapped. The top level
    // applies the per-byte bit reversal when it drives ICAP_SPARTAN6.
    localparam logic [15:0] DUMMY     = 16'hFFFF;
    localparam logic [15:0] SYNC1     = 16'hAA99;
    localparam logic [15:0] SYNC2     = 16'h5566;
    localparam logic [15:0] WR_GEN1   = 16'h3261;
    localparam logic [15:0] WR_GEN2   = 16'h3281;
    localparam logic [15:0] WR_GEN3   = 16'h32A1;
    localparam logic [15:0] WR_GEN4   = 16'h32C1;
    localparam logic [15:0] WR_CMD    = 16'h30A1;
    localparam logic [15:0] CMD_IPROG = 16'h000E;
    localparam logic [15:0] NOOP      = 16'h2000;

    localparam int          SEQ_LEN   = 14;
    localparam logic [3:0]  LAST_IDX  = 4'(SEQ_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    // Reverses the bit order inside each byte and keeps the byte positions.
    function automatic logic [15:0] bit_swap_bytes(input logic [15:0] w);
        logic [15:0] r;
        r = '0;
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 8; j++) begin
                r[8*k + j] = w[8*k + 7 - j];
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/icap_reboot_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : icap_reboot_seq_if
// Purpose  : Groups the boot-register inputs and the ICAP primitive port of
//            the reboot sequencer.
//   spi_addr  : MultiBoot SPI address. Bits [23:0] are used.
//   reboot    : reboot request level, asynchronous to icap_clk.
//   icap_busy : ICAP BUSY.
//   icap_ce_n, icap_we_n, icap_o : ICAP CE (active low), RDWRB, data word.
//   busy, done : sequencer status.
//   master = the sequencer; slave = register block plus ICAP side.
// Revision : 1.0 - initial release
// ============================================================================
interface icap_reboot_seq_if;
    logic [24:0] spi_addr;
    logic        reboot;
    logic        icap_busy;
    logic        icap_ce_n;
    logic        icap_we_n;
    logic [15:0] icap_o;
    logic        busy;
    logic        done;

    modport master (
        input  spi_addr, reboot, icap_busy,
        output icap_ce_n, icap_we_n, icap_o, busy, done
    );

    modport slave (
        output spi_addr, reboot, icap_busy,
        input  icap_ce_n, icap_we_n, icap_o, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/icap_reboot_seq_sync2.sv
`default_nettype none
// ============================================================================
// Module   : sync2
// Purpose  : Two-flop level synchroniser. It has a synchronous active-high
//            reset and clears to 0.
//   clk, rst : destination clock and reset.
//   d_i      : asynchronous input level.
//   q_o      : synchronised level, two clk edges later.
// Revision : 1.0 - initial release
// ============================================================================
module sync2 (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic d_i,
    output logic      q_o
);
    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;
endmodule
`default_nettype wire

// File: rtl/icap_reboot_seq.sv
`default_nettype none
// ============================================================================
// Module   : icap_reboot_seq
// Purpose  : Turns a reboot request into the Spartan-6 IPROG write sequence.
//            The sequence writes the MultiBoot address (GENERAL1/2) and the
//            fallback address (GENERAL3/4), then issues IPROG.
//   icap_clk : sole clock.
//   rst      : synchronous active-high reset.
//   bus      : master side of icap_reboot_seq_if. It carries spi_addr,
//              reboot and icap_busy in, and icap_ce_n, icap_we_n, icap_o,
//              busy and done out. All outputs are registered.
// Parameters:
//   FALLBACK_ADDR : golden image SPI byte address.
//   READ_OPCODE   : SPI read opcode placed in GENERAL2/4 upper byte.
//   SWAP_BITS     : bit-reverse each output byte (1 for ICAP_SPARTAN6).
// Revision : 1.0 - initial release
// ============================================================================
module icap_reboot_seq
    import icap_reboot_seq_pkg::*;
#(
    parameter logic [23:0] FALLBACK_ADDR = 24'h000000,
    parameter logic [7:0]  READ_OPCODE   = 8'h0B,
    parameter bit          SWAP_BITS     = 1'b1
) (
    input  wire logic             icap_clk,
    input  wire logic             rst,
    icap_reboot_seq_if.master     bus
);
    logic        reboot_s2;
    logic        s3_q;
    logic [1:0]  vld_q;
    logic        armed_q, armed_d;
    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [23:0] addr_q, addr_d;
    logic        trig;
    logic [15:0] word_raw;
    logic [15:0] word_out;

    logic        ce_n_q, ce_n_d;
    logic        we_n_q, we_n_d;
    logic [15:0] icap_o_q, icap_o_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    // spi_addr[24] has no meaning for a 24-bit SPI address.
    logic        unused_spi_msb;
    assign unused_spi_msb = bus.spi_addr[24];

    sync2 u_sync2 (
        .clk (icap_clk),
        .rst (rst),
        .d_i (bus.reboot),
        .q_o (reboot_s2)
    );

    // vld_q fills with ones two cycles after reset. Before that, reboot_s2
    // still shows the reset value of the synchroniser and not a real sample
    // of reboot. So a request held high through reset cannot arm the
    // trigger until it has actually been seen low.
    assign trig = reboot_s2 & ~s3_q & armed_q;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        armed_d  = armed_q;
        ce_n_d   = 1'b1;
        we_n_d   = 1'b1;
        icap_o_d = 16'hFFFF;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        if (vld_q[1] && !reboot_s2) begin
            armed_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (trig) begin
                    addr_d  = bus.spi_addr[23:0];
                    idx_d   = '0;
                    armed_d = 1'b0;
                    state_d = SEND;
                end
            end
            SEND: begin
                busy_d   = 1'b1;
                we_n_d   = 1'b0;
                icap_o_d = word_out;
                if (!bus.icap_busy) begin
                    ce_n_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            DONE: begin
                done_d = 1'b1;
                if (!reboot_s2) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Word ROM. The addresses come from the latched copy, so later changes
    // on spi_addr do not affect a sequence that has already started.
    always_comb begin
        word_raw = NOOP;
        case (idx_q)
            4'd0:    word_raw = DUMMY;
            4'd1:    word_raw = SYNC1;
            4'd2:    word_raw = SYNC2;
            4'd3:    word_raw = WR_GEN1;
            4'd4:    word_raw = addr_q[15:0];
            4'd5:    word_raw = WR_GEN2;
            4'd6:    word_raw = {READ_OPCODE, addr_q[23:16]};
            4'd7:    word_raw = WR_GEN3;
            4'd8:    word_raw = FALLBACK_ADDR[15:0];
            4'd9:    word_raw = WR_GEN4;
            4'd10:   word_raw = {READ_OPCODE, FALLBACK_ADDR[23:16]};
            4'd11:   word_raw = WR_CMD;
            4'd12:   word_raw = CMD_IPROG;
            4'd13:   word_raw = NOOP;
            default: word_raw = NOOP;
        endcase
    end

    generate
        if (SWAP_BITS) begin : g_swap
            assign word_out = bit_swap_bytes(word_raw);
        end else begin : g_noswap
            assign word_out = word_raw;
        end
    endgenerate

    always_ff @(posedge icap_clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            addr_q   <= '0;
            armed_q  <= 1'b0;
            s3_q     <= 1'b0;
            vld_q    <= '0;
            ce_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
            icap_o_q <= 16'hFFFF;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            addr_q   <= addr_d;
            armed_q  <= armed_d;
            s3_q     <= reboot_s2;
            vld_q    <= {vld_q[0], 1'b1};
            ce_n_q   <= ce_n_d;
            we_n_q   <= we_n_d;
            icap_o_q <= icap_o_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.icap_ce_n = ce_n_q;
    assign bus.icap_we_n = we_n_q;
    assign bus.icap_o    = icap_o_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule
`default_nettype wire

// File: tb/tb_icap_reboot_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_icap_reboot_seq
// Purpose  : Self-checking bench for icap_reboot_seq. Two instances share the
//            same stimulus: one uses default parameters without bit swap, the
//            other uses bit swap with a non-default fallback address and
//            opcode. The expected word lists come from the command table,
//            built by plain lookup.
// Revision : 1.0 - initial release
// ============================================================================
module tb_icap_reboot_seq;
    localparam logic [23:0] FB1 = 24'hA5C3F0;
    localparam logic [7:0]  OP1 = 8'h6B;
    localparam int          NW  = 14;

    logic icap_clk = 1'b0;
    logic rst;
    always #5 icap_clk = ~icap_clk;

    icap_reboot_seq_if if0 ();
    icap_reboot_seq_if if1 ();

    icap_reboot_seq #(.SWAP_BITS(1'b0)) u_dut0 (
        .icap_clk (icap_clk),
        .rst      (rst),
        .bus      (if0)
    );

    icap_reboot_seq #(.FALLBACK_ADDR(FB1), .READ_OPCODE(OP1), .SWAP_BITS(1'b1)) u_dut1 (
        .icap_clk (icap_clk),
        .rst      (rst),
        .bus      (if1)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic        ce [2];
    logic        we [2];
    logic        bsy[2];
    logic        dn [2];
    logic [15:0] o  [2];

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input logic [24:0] a, input logic rb, input logic bz);
        if0.spi_addr = a; if0.reboot = rb; if0.icap_busy = bz;
        if1.spi_addr = a; if1.reboot = rb; if1.icap_busy = bz;
    endtask

    task automatic tick();
        @(posedge icap_clk);
        #1;
    endtask

    task automatic sample();
        ce[0] = if0.icap_ce_n; we[0] = if0.icap_we_n; o[0] = if0.icap_o;
        bsy[0] = if0.busy; dn[0] = if0.done;
        ce[1] = if1.icap_ce_n; we[1] = if1.icap_we_n; o[1] = if1.icap_o;
        bsy[1] = if1.busy; dn[1] = if1.done;
    endtask

    // Reference word i of the IPROG sequence for instance k.
    function automatic logic [15:0] exp_word(input int k, input logic [23:0] a, input int i);
        logic [15:0] tbl [NW];
        logic [23:0] fb;
        logic [7:0]  op, hi, lo, hr, lr;
        fb  = (k == 1) ? FB1 : 24'h000000;
        op  = (k == 1) ? OP1 : 8'h0B;
        tbl = '{16'hFFFF, 16'hAA99, 16'h5566, 16'h3261, a[15:0], 16'h3281,
                {op, a[23:16]}, 16'h32A1, fb[15:0], 16'h32C1, {op, fb[23:16]},
                16'h30A1, 16'h000E, 16'h2000};
        if (k == 1) begin
            hi = tbl[i][15:8];
            lo = tbl[i][7:0];
            hr = {<<{hi}};
            lr = {<<{lo}};
            return {hr, lr};
        end
        return tbl[i];
    endfunction

    task automatic check_reset_outputs(input string nm);
        for (int k = 0; k < 2; k++) begin
            check_value($sformatf("%s d%0d ce_n", nm, k), ce[k], 1);
            check_value($sformatf("%s d%0d we_n", nm, k), we[k], 1);
            check_value($sformatf("%s d%0d icap_o", nm, k), o[k], 16'hFFFF);
            check_value($sformatf("%s d%0d busy", nm, k), bsy[k], 0);
            check_value($sformatf("%s d%0d done", nm, k), dn[k], 0);
        end
    endtask

    // Counts CE-low cycles over a window in which nothing may start.
    task automatic check_idle(input string nm, input int n);
        int hits[2];
        hits = '{0, 0};
        for (int c = 0; c < n; c++) begin
            tick();
            sample();
            for (int k = 0; k < 2; k++) if (!ce[k] || bsy[k]) hits[k]++;
        end
        for (int k = 0; k < 2; k++)
            check_value($sformatf("%s d%0d active cycles", nm, k), hits[k], 0);
    endtask

    // Runs one reboot sequence. Timing is counted from the step after
    // reboot rises: SEND cycle s runs after step s+3 and appears on the
    // outputs at step s+4. stall_* / chg_* / rep_* / rst_at are SEND-cycle
    // numbers (-1 = unused).
    task automatic run_seq(input string nm, input logic [24:0] addr, input int low_n,
                           input int stall_at, input int stall_n,
                           input int chg_at, input logic [24:0] chg_addr,
                           input int rep_at, input int rst_at);
        int          nword[2];
        int          total;
        int          s;
        logic        prev_bz, bz, rb;
        logic [24:0] cur_addr;
        bit          fell;

        cur_addr = addr;
        drive(addr, 1'b0, 1'b0);
        repeat (low_n) tick();
        drive(addr, 1'b1, 1'b0);
        prev_bz = 1'b0;
        nword   = '{0, 0};
        total   = NW + stall_n;

        for (int t = 1; t <= total + 4; t++) begin
            tick();
            sample();
            for (int k = 0; k < 2; k++) begin
                if (t < 4) begin
                    check_value($sformatf("%s d%0d pre ce_n t%0d", nm, k, t), ce[k], 1);
                end else if (t - 4 < total) begin
                    check_value($sformatf("%s d%0d ce_n t%0d", nm, k, t), ce[k], prev_bz);
                    check_value($sformatf("%s d%0d busy t%0d", nm, k, t), bsy[k], 1);
                    check_value($sformatf("%s d%0d word%0d t%0d", nm, k, nword[k], t),
                                o[k], exp_word(k, addr[23:0], (nword[k] < NW) ? nword[k] : NW - 1));
                    if (!ce[k]) begin
                        check_value($sformatf("%s d%0d we_n t%0d", nm, k, t), we[k], 0);
                        nword[k]++;
                    end
                end else begin
                    check_value($sformatf("%s d%0d word count", nm, k), nword[k], NW);
                    check_value($sformatf("%s d%0d done", nm, k), dn[k], 1);
                    check_value($sformatf("%s d%0d busy end", nm, k), bsy[k], 0);
                    check_value($sformatf("%s d%0d ce_n end", nm, k), ce[k], 1);
                    check_value($sformatf("%s d%0d icap_o end", nm, k), o[k], 16'hFFFF);
                end
            end

            s  = t - 3;
            bz = (stall_n > 0) && (s >= stall_at) && (s < stall_at + stall_n);
            rb = !((rep_at >= 0) && (s >= rep_at) && (s < rep_at + 3));
            if (chg_at >= 0 && s >= chg_at) cur_addr = chg_addr;

            if (rst_at >= 0 && s == rst_at) begin
                rst = 1'b1;
                drive(cur_addr, 1'b1, 1'b0);
                tick();
                sample();
                check_reset_outputs({nm, " mid-rst"});
                rst = 1'b0;
                return;
            end
            drive(cur_addr, rb, bz);
            prev_bz = bz;
        end

        // DONE holds while reboot stays high, then clears once it drops.
        tick();
        sample();
        for (int k = 0; k < 2; k++)
            check_value($sformatf("%s d%0d done held", nm, k), dn[k], 1);
        drive(cur_addr, 1'b0, 1'b0);
        fell = 1'b0;
        for (int c = 0; c < 10 && !fell; c++) begin
            tick();
            sample();
            if (!dn[0] && !dn[1]) fell = 1'b1;
        end
        check_value({nm, " done release"}, fell, 1);
        check_reset_outputs({nm, " after done"});
        check_idle({nm, " post"}, 20);
    endtask

    initial begin
        rst = 1'b1;
        drive(25'h080000, 1'b1, 1'b0);
        repeat (4) tick();
        sample();
        check_reset_outputs("reset");
        rst = 1'b0;

        check_idle("held through reset", 20);
        run_seq("basic", 25'h080000, 2, -1, 0, -1, 25'h0, -1, -1);
        run_seq("stall", 25'h080000, 3, 4, 3, -1, 25'h0, -1, -1);
        run_seq("latch", 25'h080000, 3, -1, 0, 2, 25'h0C0000, 3, -1);
        run_seq("midrst", 25'h080000, 3, -1, 0, -1, 25'h0, -1, 7);
        check_idle("after mid-rst", 15);
        run_seq("fresh", 25'h080000, 3, -1, 0, -1, 25'h0, -1, -1);

        for (int r = 0; r < 8; r++) begin
            logic [24:0] ra;
            int          sa, sn;
            ra = 25'($urandom);
            sa = int'($urandom_range(0, 13));
            sn = int'($urandom_range(0, 4));
            run_seq($sformatf("rand%0d", r), ra, 3, sa, sn, -1, 25'h0, -1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
